dmem_responder: RTL and testbench

//  Data-memory responder: the slave end of the pipeline's load/store port.

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word request at a time and answers a load or a
// byte-masked store after LATENCY edges, so the requester's stall path gets exercised.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int   IDX_W  = $clog2(DEPTH_WORDS);
    localparam int   CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic DIRECT = (LATENCY == 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             we_q, err_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;

    logic [31:0]      mem_q [DEPTH_WORDS];

    // Offset carries a borrow bit so "below BASE_ADDR" falls out of the subtraction.
    logic [32:0]      offset;
    logic             req_err;
    logic [IDX_W-1:0] req_idx;

    assign offset  = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign req_err = offset[32] || (offset[1:0] != 2'b00) || (offset[31:IDX_W+2] != '0);
    assign req_idx = offset[IDX_W+1:2];

    logic accept, enter_resp, wr_en;
    logic             cur_we, cur_err;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_be;

    assign accept     = (state_q == ST_IDLE) && req_valid;
    assign enter_resp = (accept && DIRECT) || ((state_q == ST_BUSY) && (cnt_q == CNT_W'(1)));

    // With LATENCY=1 the request enters RESP on its own acceptance edge, before the
    // latched copy exists, so the live inputs feed the access in that case.
    assign cur_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign cur_err   = (state_q == ST_IDLE) ? req_err   : err_q;
    assign cur_idx   = (state_q == ST_IDLE) ? req_idx   : idx_q;
    assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign cur_be    = (state_q == ST_IDLE) ? req_be    : be_q;

    assign wr_en = enter_resp && cur_we && !cur_err && reset;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = DIRECT ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            rsp_err_d = cur_err;
            rdata_d   = (cur_err || cur_we) ? 32'h0 : mem_q[cur_idx];
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
            if (accept) begin
                we_q    <= req_we;
                err_q   <= req_err;
                idx_q   <= req_idx;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // NOTE: the array has no reset; clearing it would turn the RAM into a flop bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) mem_q[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 5) driven by directed
// requests; expected responses are queued at issue and checked by a monitor.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(256),
            .LATENCY    (g == 0 ? 2 : (g == 1 ? 1 : 5)),
            .BASE_ADDR  (32'h0)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   low_cnt [3] = '{0, 0, 0};
    bit   ignore_ready = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: requester samples at the next rising edge, so that edge number is cyc+1.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ignore_ready) low_cnt[d] = 0;
            else if (!req_ready[d]) low_cnt[d]++;
            else if (low_cnt[d] != 0) begin
                check("ready_low_cycles", low_cnt[d], lat_of(d));
                low_cnt[d] = 0;
            end
            if (rsp_valid[d]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", {31'b0, rsp_valid[d]}, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_dut", d, mon_e.dut);
                    check("rsp_edge", cyc + 1, mon_e.due);
                    check("rsp_rdata", rsp_rdata[d], mon_e.rdata);
                    check("rsp_err", {31'b0, rsp_err[d]}, {31'b0, mon_e.err});
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge
    // with req_valid still high so back-to-back requests keep it asserted.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err, input bit push);
        int waited = 0;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        while (!req_ready[d] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[d]) begin
            check("accept_timeout", {31'b0, req_ready[d]}, 32'h1);
            req_valid[d] = 1'b0;
        end else begin
            if (push) exp_q.push_back('{d, cyc + 1 + lat_of(d), exp_rdata, exp_err});
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drop(input int d);
        req_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
            req_be[d]    = 4'h0;
        end
        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, req_ready[0]}, 32'h1);
        check("reset_valid", {31'b0, rsp_valid[0]}, 32'h0);
        check("reset_rdata", rsp_rdata[0], 32'h0);
        check("reset_err", {31'b0, rsp_err[0]}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        ignore_ready = 1'b0;

        // Full-word store then load back.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1); drop(0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1); drop(0);

        // Byte-masked store, then the be=0000 no-op store.
        issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b1); drop(0);
        issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, 1'b1); drop(0);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1); drop(0);
        issue(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1'b1); drop(0);
        issue(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, 1'b1); drop(0);

        // Error cases and the last valid word.
        issue(0, 1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1); drop(0);
        issue(0, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1); drop(0);
        issue(0, 1'b1, 32'h12, 32'h55555555, 4'hF, 32'h0, 1'b1, 1'b1); drop(0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1); drop(0);
        issue(0, 1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1'b1); drop(0);
        issue(0, 1'b0, 32'h3FC, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 1'b1); drop(0);

        // Back-to-back loads with req_valid held high throughout.
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h3FC, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 1'b1);
        drop(0);
        drain();

        // Reset during BUSY of a store: outputs clear at once, the store never lands.
        issue(0, 1'b1, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1); drop(0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1); drop(0);
        drain();
        ignore_ready = 1'b1;
        issue(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0); drop(0);
        check("busy_before_reset", {31'b0, req_ready[0]}, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_mid_ready", {31'b0, req_ready[0]}, 32'h1);
        check("rst_mid_valid", {31'b0, rsp_valid[0]}, 32'h0);
        check("rst_mid_rdata", rsp_rdata[0], 32'h0);
        check("rst_mid_err", {31'b0, rsp_err[0]}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        ignore_ready = 1'b0;
        issue(0, 1'b0, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1); drop(0);
        drain();

        // Same store/load on the LATENCY=1 and LATENCY=5 instances.
        for (int d = 1; d < 3; d++) begin
            issue(d, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1); drop(d);
            issue(d, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1); drop(d);
            drain();
        end

        check("queue_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
